// File: rtl/axi4_wr_arbiter_2m.sv
// ---------------------------------------------------------------------------
// axi4_wr_arbiter_2m
// Two-master to one-slave AXI4 write-path arbiter (AW/W/B). One master owns
// the slave from its AW handshake until its B handshake. When both masters
// request together, the master held in rr wins, which gives round-robin
// fairness. The slave WLAST comes from a local beat counter. A master WLAST
// that disagrees with that counter raises protocol_err for one cycle.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   m_aw*, m_w*, m_b*     packed per-master channels, master i at [i*W +: W]
//   s_aw*, s_w*, s_b*     single slave-side channels
//   grant_o               one-hot current owner, 0 while idle
//   protocol_err          one-cycle pulse on a master WLAST mismatch
// ---------------------------------------------------------------------------
module axi4_wr_arbiter_2m #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [2*ADDR_WIDTH-1:0] m_awaddr,
    input  logic [15:0]             m_awlen,
    input  logic [5:0]              m_awsize,
    input  logic [1:0]              m_awvalid,
    output logic [1:0]              m_awready,
    input  logic [2*DATA_WIDTH-1:0] m_wdata,
    input  logic [1:0]              m_wlast,
    input  logic [1:0]              m_wvalid,
    output logic [1:0]              m_wready,
    output logic [3:0]              m_bresp,
    output logic [1:0]              m_bvalid,
    input  logic [1:0]              m_bready,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [7:0]              s_awlen,
    output logic [2:0]              s_awsize,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic                    s_wlast,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic [1:0]              grant_o,
    output logic                    protocol_err
);

    // state | meaning
    // IDLE  | no owner, waiting for any m_awvalid
    // ADDR  | owner's AW forwarded to the slave
    // DATA  | owner's W beats forwarded, beat counted against len
    // RESP  | slave B routed back to the owner
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t     state, state_nxt;
    logic       gnt, gnt_nxt;
    logic       rr, rr_nxt;
    logic [7:0] len, len_nxt;
    logic [7:0] beat, beat_nxt;
    logic       perr_nxt;

    logic       last_beat;
    logic [7:0] sel_awlen;

    // Data-path selects depend only on the registered gnt, so there is no
    // combinational path from any valid to the grant.
    assign s_awaddr  = gnt ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_awaddr[ADDR_WIDTH-1:0];
    assign sel_awlen = gnt ? m_awlen[15:8] : m_awlen[7:0];
    assign s_awlen   = sel_awlen;
    assign s_awsize  = gnt ? m_awsize[5:3] : m_awsize[2:0];
    assign s_wdata   = gnt ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
    assign last_beat = (beat == len);
    assign s_wlast   = (state == DATA) && last_beat;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            rr           <= 1'b0;
            len          <= 8'd0;
            beat         <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            gnt          <= gnt_nxt;
            rr           <= rr_nxt;
            len          <= len_nxt;
            beat         <= beat_nxt;
            protocol_err <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        len_nxt   = len;
        beat_nxt  = beat;
        perr_nxt  = 1'b0;
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        m_bresp   = 4'b0000;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        grant_o   = 2'b00;

        case (state)
            IDLE: begin
                if (|m_awvalid) begin
                    // Single requester wins outright; a tie goes to rr.
                    gnt_nxt   = (&m_awvalid) ? rr : m_awvalid[1];
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_awvalid      = m_awvalid[gnt];
                m_awready[gnt] = s_awready;
                if (m_awvalid[gnt] && s_awready) begin
                    len_nxt   = sel_awlen;
                    beat_nxt  = 8'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                s_wvalid      = m_wvalid[gnt];
                m_wready[gnt] = s_wready;
                if (m_wvalid[gnt] && s_wready) begin
                    beat_nxt = beat + 8'd1;
                    perr_nxt = (m_wlast[gnt] != last_beat);
                    if (last_beat) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                m_bvalid[gnt] = s_bvalid;
                if (gnt) begin
                    m_bresp[3:2] = s_bresp;
                end else begin
                    m_bresp[1:0] = s_bresp;
                end
                s_bready = m_bready[gnt];
                if (s_bvalid && m_bready[gnt]) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~gnt;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE) begin
            grant_o = gnt ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_axi4_wr_arbiter_2m.sv
module tb_axi4_wr_arbiter_2m;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] m_awaddr;
    logic [15:0] m_awlen;
    logic [5:0]  m_awsize;
    logic [1:0]  m_awvalid;
    logic [1:0]  m_awready;
    logic [63:0] m_wdata;
    logic [1:0]  m_wlast;
    logic [1:0]  m_wvalid;
    logic [1:0]  m_wready;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready;
    logic [15:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [1:0]  grant_o;
    logic        protocol_err;

    axi4_wr_arbiter_2m #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant_o(grant_o), .protocol_err(protocol_err)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] w_exp [$];
    logic [1:0]  b_exp0 [$];
    logic [1:0]  b_exp1 [$];

    int   viol_cnt  = 0;
    int   perr_cnt  = 0;
    int   perr_wide = 0;
    bit   wready_toggle = 1'b0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // kind 0: m_awready, 1: m_wready, 2: m_bvalid. Returns #1 after the handshake edge.
    task automatic wait_hs(input int kind, input int m, input string tag);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge ACLK);
            n++;
            case (kind)
                0: ok = m_awready[m];
                1: ok = m_wready[m];
                default: ok = m_bvalid[m];
            endcase
        end while (!ok && n < 300);
        if (!ok) chk_val(tag, 0, 1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic mwrite(input int m, input logic [15:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input int bad_beat, input logic [1:0] resp);
        if (m == 0) b_exp0.push_back(resp); else b_exp1.push_back(resp);
        m_awaddr[m*16 +: 16] = addr;
        m_awlen[m*8 +: 8]    = len;
        m_awsize[m*3 +: 3]   = 3'd2;
        m_awvalid[m]         = 1'b1;
        wait_hs(0, m, "aw_timeout");
        m_awvalid[m] = 1'b0;
        for (int i = 0; i <= int'(len); i++) w_exp.push_back({(i == int'(len)), base + i});
        for (int i = 0; i <= int'(len); i++) begin
            m_wdata[m*32 +: 32] = base + i;
            m_wlast[m]          = (i == int'(len)) || (i == bad_beat);
            m_wvalid[m]         = 1'b1;
            wait_hs(1, m, "w_timeout");
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        m_bready[m] = 1'b1;
        wait_hs(2, m, "b_timeout");
        m_bready[m] = 1'b0;
    endtask

    task automatic aw_latency(input int m);
        @(negedge ACLK);
        chk_val("aw_lat_early", s_awvalid, 0);
        @(negedge ACLK);
        chk_val("aw_lat_1cyc", s_awvalid, 1);
        chk_val("aw_lat_grant", grant_o, (m == 1) ? 2'b10 : 2'b01);
    endtask

    task automatic grant_order;
        int n;
        n = 0;
        do begin @(negedge ACLK); n++; end while (grant_o == 2'b00 && n < 300);
        chk_val("tie_first_grant", grant_o, 2'b01);
        n = 0;
        do begin @(negedge ACLK); n++; end while (grant_o != 2'b10 && n < 300);
        chk_val("tie_second_grant", grant_o, 2'b10);
    endtask

    // Slave model: AWREADY always high, WREADY constant or toggling, B one
    // cycle after the last W beat, SLVERR for address 0xFFF1.
    initial begin
        logic [15:0] cap_addr;
        bit aw_hs, wl_hs, b_hs;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        cap_addr  = 16'h0;
        forever begin
            @(negedge ACLK);
            aw_hs = s_awvalid && s_awready;
            wl_hs = s_wvalid && s_wready && s_wlast;
            b_hs  = s_bvalid && s_bready;
            if (aw_hs) cap_addr = s_awaddr;
            @(posedge ACLK);
            #1;
            if (b_hs) s_bvalid = 1'b0;
            if (wl_hs) begin
                s_bvalid = 1'b1;
                s_bresp  = (cap_addr == 16'hFFF1) ? 2'b10 : 2'b00;
            end
            s_wready = wready_toggle ? ~s_wready : 1'b1;
        end
    end

    // Scoreboard and invariant monitor.
    initial begin
        logic [32:0] e;
        logic [1:0]  r;
        bit perr_prev;
        perr_prev = 1'b0;
        forever begin
            @(negedge ACLK);
            if (s_wvalid && s_wready) begin
                if (w_exp.size() == 0) chk_val("w_unexpected", 1, 0);
                else begin
                    e = w_exp.pop_front();
                    chk_val("s_wdata", s_wdata, e[31:0]);
                    chk_val("s_wlast", s_wlast, e[32]);
                end
            end
            if (m_bvalid[0] && m_bready[0]) begin
                if (b_exp0.size() == 0) chk_val("b0_unexpected", 1, 0);
                else begin r = b_exp0.pop_front(); chk_val("m_bresp0", m_bresp[1:0], r); end
                chk_val("m_bvalid1_quiet", m_bvalid[1], 0);
                chk_val("m_bresp1_quiet", m_bresp[3:2], 0);
            end
            if (m_bvalid[1] && m_bready[1]) begin
                if (b_exp1.size() == 0) chk_val("b1_unexpected", 1, 0);
                else begin r = b_exp1.pop_front(); chk_val("m_bresp1", m_bresp[3:2], r); end
                chk_val("m_bvalid0_quiet", m_bvalid[0], 0);
                chk_val("m_bresp0_quiet", m_bresp[1:0], 0);
            end
            if (grant_o == 2'b01 && (m_awready[1] || m_wready[1] || m_bvalid[1])) viol_cnt++;
            if (grant_o == 2'b10 && (m_awready[0] || m_wready[0] || m_bvalid[0])) viol_cnt++;
            if (protocol_err) begin
                perr_cnt++;
                if (perr_prev) perr_wide++;
            end
            perr_prev = protocol_err;
        end
    end

    initial begin
        int p0;
        ARESET    = 1'b1;
        m_awaddr  = '0; m_awlen = '0; m_awsize = '0; m_awvalid = '0;
        m_wdata   = '0; m_wlast = '0; m_wvalid = '0; m_bready  = '0;
        step(2);
        ARESET = 1'b0;
        chk_val("rst_grant", grant_o, 0);
        chk_val("rst_awready", m_awready, 0);
        chk_val("rst_s_valids", {s_awvalid, s_wvalid, s_bready}, 0);
        chk_val("rst_perr", protocol_err, 0);

        // Single M0 write.
        fork
            mwrite(0, 16'h0010, 8'd0, 32'hDEADBEEF, -1, 2'b00);
            aw_latency(0);
        join
        step(1);
        chk_val("t1_idle", grant_o, 0);
        chk_val("t1_rr", dut.rr, 1);

        // Simultaneous request after reset: M0 first, then M1.
        ARESET = 1'b1;
        step(1);
        ARESET = 1'b0;
        fork
            mwrite(0, 16'h0100, 8'd1, 32'h0000_0100, -1, 2'b00);
            mwrite(1, 16'h0200, 8'd1, 32'h0000_0200, -1, 2'b00);
            grant_order();
        join
        step(1);

        // M1 burst with toggling WREADY.
        wready_toggle = 1'b1;
        mwrite(1, 16'h0300, 8'd3, 32'h0000_0001, -1, 2'b00);
        wready_toggle = 1'b0;
        step(1);

        // M0 burst with an early WLAST on the second beat.
        p0 = perr_cnt;
        mwrite(0, 16'h0400, 8'd3, 32'h0000_00A0, 1, 2'b00);
        step(2);
        chk_val("perr_pulses", perr_cnt - p0, 1);
        chk_val("perr_width", perr_wide, 0);

        // SLVERR pass-through to M1.
        mwrite(1, 16'hFFF1, 8'd0, 32'h0000_0055, -1, 2'b10);
        step(1);

        // Reset in the middle of an AWLEN=7 burst from M0.
        m_awaddr[15:0] = 16'h0500;
        m_awlen[7:0]   = 8'd7;
        m_awvalid[0]   = 1'b1;
        wait_hs(0, 0, "rst_aw_timeout");
        m_awvalid[0] = 1'b0;
        for (int i = 0; i < 8; i++) w_exp.push_back({(i == 7), 32'h0000_0B00 + i});
        for (int i = 0; i < 3; i++) begin
            m_wdata[31:0] = 32'h0000_0B00 + i;
            m_wvalid[0]   = 1'b1;
            wait_hs(1, 0, "rst_w_timeout");
        end
        m_wdata[31:0] = 32'h0000_0B03;
        ARESET = 1'b1;
        step(1);
        chk_val("midrst_grant", grant_o, 0);
        chk_val("midrst_s_valids", {s_awvalid, s_wvalid, s_bready}, 0);
        chk_val("midrst_m_ready", {m_awready, m_wready, m_bvalid}, 0);
        chk_val("midrst_state", dut.state, 0);
        ARESET      = 1'b0;
        m_wvalid[0] = 1'b0;
        w_exp.delete();
        fork
            mwrite(1, 16'h0600, 8'd0, 32'h0000_0C00, -1, 2'b00);
            aw_latency(1);
        join
        step(2);

        chk_val("w_exp_drained", w_exp.size(), 0);
        chk_val("b0_drained", b_exp0.size(), 0);
        chk_val("b1_drained", b_exp1.size(), 0);
        chk_val("non_granted_quiet", viol_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
